// File: rtl/common.sv
// Shared fetch-stage types and widths.
// Holds the fetch FSM enum, datapath widths and the default boot PC.
package common;

  localparam int PC_WIDTH    = 64;
  localparam int INSTR_WIDTH = 32;

  localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_PC =
    64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, single-word ibus reads, one-entry output buffer.
// Ports: clk/reset, block, flush/redirect targets, ibus req/addr/ready/data,
// buffered pc_out/instr_out with if_finish valid.
module if_fetch_stage
  import common::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   block,
  input  logic                   pipeline_flush,
  input  logic [PC_WIDTH-1:0]    flush_pc,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   ibus_req,
  output logic [PC_WIDTH-1:0]    ibus_addr,
  input  logic                   ibus_ready,
  input  logic [INSTR_WIDTH-1:0] ibus_data,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   if_finish
);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] tgt;
  logic                ctl;
  logic                pop;
  logic                issue;
  logic                resp;
  logic                keep;

  assign ctl = pipeline_flush | redirect_valid;
  assign pop = if_finish & ~block;

  // Flush wins over redirect; targets are word aligned.
  assign tgt = (pipeline_flush ? flush_pc : redirect_pc)
             & ~PC_WIDTH'(3);

  assign issue = (state == IDLE) && (state_nxt == REQ);
  assign resp  = (state != IDLE) && ibus_ready;
  assign keep  = (state == REQ) && ibus_ready && !ctl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!ctl && (!if_finish || pop))
          state_nxt = REQ;
      end
      REQ: begin
        if (ibus_ready)   state_nxt = IDLE;
        else if (ctl)     state_nxt = DRAIN;
      end
      DRAIN: begin
        if (ibus_ready)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      ibus_req  <= 1'b0;
      ibus_addr <= '0;
      pc_out    <= '0;
      instr_out <= '0;
      if_finish <= 1'b0;
    end else begin
      if (ctl)       pc <= tgt;
      else if (keep) pc <= pc + PC_WIDTH'(4);

      // Address is held after the response; it only moves on issue.
      if (issue) begin
        ibus_req  <= 1'b1;
        ibus_addr <= pc;
      end else if (resp) begin
        ibus_req  <= 1'b0;
      end

      if (ctl) begin
        if_finish <= 1'b0;
        pc_out    <= '0;
        instr_out <= '0;
      end else if (keep) begin
        if_finish <= 1'b1;
        pc_out    <= ibus_addr;
        instr_out <= ibus_data;
      end else if (pop) begin
        if_finish <= 1'b0;
      end
    end
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline. It owns the program counter, issues single-word reads on the instruction bus, and holds one fetched instruction in a one-entry output buffer. The buffer drives `pc_out`, `instr_out` and `if_finish` into the decode stage. Redirects from EX (taken branch/jump) and pipeline flushes from the CSR/trap logic retarget the PC. A redirect or flush that arrives during an outstanding bus read discards that read's response.

## Interface
Parameters:
- `RESET_PC`, default `64'h0000_0000_8000_0000`: first fetch address after reset.

Ports:
- `clk` input 1: clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `block` input 1: decode stall. The buffer entry is not consumed while high.
- `pipeline_flush` input 1: trap/CSR flush. Highest priority.
- `flush_pc` input 64: target address for `pipeline_flush`.
- `redirect_valid` input 1: taken branch/jump from EX.
- `redirect_pc` input 64: target address for `redirect_valid`.
- `ibus_req` output 1: read request, registered.
- `ibus_addr` output 64: read address, registered, bits [1:0] always 0.
- `ibus_ready` input 1: response valid. Sampled only while `ibus_req`=1.
- `ibus_data` input 32: instruction word, valid when `ibus_ready`=1.
- `pc_out` output 64: PC of the buffered instruction.
- `instr_out` output 32: buffered instruction.
- `if_finish` output 1: buffer holds a valid, unconsumed instruction.

## Operation
- Reset values: PC=`RESET_PC`, state=IDLE, `ibus_req`=0, `ibus_addr`=0, `pc_out`=0, `instr_out`=0, `if_finish`=0.
- Pop condition: `if_finish` && !`block`. The buffer is consumed on that edge.
- FSM states:
  - IDLE: no bus read outstanding.
  - REQ: `ibus_req`=1, response will be kept.
  - DRAIN: `ibus_req`=1, response will be discarded.
- IDLE → REQ:
  - Taken when the buffer is empty or popping this cycle, and no flush/redirect is present.
  - Next cycle `ibus_req`=1 and `ibus_addr`=PC.
- REQ, `ibus_ready`=1, no flush/redirect:
  - Load the buffer: `pc_out`=`ibus_addr`, `instr_out`=`ibus_data`, `if_finish`=1.
  - PC = PC+4, modulo 2^64.
  - `ibus_req`=0, go to IDLE.
- REQ, `ibus_ready`=0: hold `ibus_req` and `ibus_addr` stable.
- Target selection:
  - `pipeline_flush` beats `redirect_valid`.
  - The chosen target is written to PC with bits [1:0] cleared.
  - `if_finish`, `pc_out` and `instr_out` are cleared to 0.
- Flush/redirect while in IDLE: stay in IDLE, request issued the following cycle.
- Flush/redirect while in REQ, with `ibus_ready`=0: go to DRAIN. The address is not withdrawn.
- Flush/redirect while in REQ, with `ibus_ready`=1 the same cycle: the response is discarded and the FSM goes to IDLE.
- In DRAIN:
  - On `ibus_ready`=1 the data is dropped, `ibus_req`=0, and the FSM goes to IDLE. The next fetch uses the new PC.
  - A further flush/redirect while in DRAIN overwrites PC and the FSM stays in DRAIN, or goes to IDLE if `ibus_ready`=1 that cycle.
- Flush/redirect override `block`: they clear the buffer even while `block`=1.
- While `if_finish`=0 and no flush occurs, `pc_out`/`instr_out` hold their last values.
- Bus rule: `ibus_req` never falls before `ibus_ready` has been seen. `ibus_addr` never changes while `ibus_req`=1.

## Timing
- Reset released before edge 0:
  - Edge 1: `ibus_req`=1.
  - Zero-wait memory (`ibus_ready`=1 in that cycle): `if_finish`=1 after edge 2.
- Fetch latency: 1 cycle from the issue edge to request visible, plus N wait cycles, plus 1 cycle to buffer valid.
- Throughput with zero-wait memory and `block`=0: one instruction per 2 cycles.
- `block` held high: `if_finish` stays 1, outputs stable, no new request issued.
- Flush effect: `if_finish`=0 on the edge following the flush cycle.
- First post-flush request:
  - From IDLE: one edge after that.
  - From REQ/DRAIN: one edge after the drained response.

## Structure
- Shared package `common` holds:
  - `fetch_state_t` enum {IDLE, REQ, DRAIN}.
  - `PC_WIDTH`=64 and `INSTR_WIDTH`=32.
  - Default `RESET_PC` constant.
- Single module, no sub-modules. The buffer and FSM are too small to split.

## Test plan
- Cold boot, zero-wait memory returning `32'h00000013`: `ibus_addr`=`8000_0000` at edge 1; after edge 2 `if_finish`=1, `pc_out`=`8000_0000`, `instr_out`=`00000013`; next `ibus_addr`=`8000_0004`.
- `block`=1 for 5 cycles with the buffer full: `if_finish`, `pc_out` and `instr_out` stable; `ibus_req` stays 0. Release: pop, then the next request.
- `redirect_valid` with `redirect_pc`=`8000_0100` while REQ waits 3 cycles: the FSM enters DRAIN and the returned word never appears on `instr_out`; the next `ibus_addr`=`8000_0100`.
- `pipeline_flush` (`flush_pc`=`8000_0200`) and `redirect_valid` (`8000_0100`) in the same cycle: the next fetch is from `8000_0200`; `if_finish`, `pc_out` and `instr_out` are 0.
- `redirect_pc`=`8000_0103`: the fetch address is `8000_0100`. PC at `FFFF_FFFF_FFFF_FFFC`: the following fetch is from `0`.
- Async `reset` asserted mid-REQ: all outputs return to reset values immediately; after release the fetch restarts at `RESET_PC`.
